// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst arbiter.
// Contents:
//   state_t        - burst FSM states
//   SETUP_CYC_DEF  - default ss_n-fall to first engine start delay (clk cycles)
//   GUARD_CYC_DEF  - default ss_n hold time after the last byte (clk cycles)
//   SPI_W          - byte width of the SPI engine
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        GUARD   = 3'd5
    } state_t;

    localparam int SETUP_CYC_DEF = 2;
    localparam int GUARD_CYC_DEF = 2;
    localparam int SPI_W         = 8;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req    - per-requester request level
//   ptr    - index of the previous winner; search starts at ptr+1 and wraps
//   winner - one-hot winner (all zero when no request)
//   any    - at least one request present
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    // First active request found walking upward from ptr+1 with wrap-around.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[PW'((int'(ptr) + k) % N)]) begin
                winner[PW'((int'(ptr) + k) % N)] = 1'b1;
                any                              = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one SPI byte engine between N requesters. One requester is granted
// at a time (round-robin); its slave select stays low for the whole burst and
// the engine is launched once per byte.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req/tx_byte/tx_last - per-requester request, next byte, last-byte flag
//   gnt, ss_n, busy   - one-hot grant, active-low selects, burst in progress
//   byte_done/rx_byte - per-byte completion pulse and received data
//   overrun           - pulse when a burst is cut at MAX_BYTES
//   eng_start/eng_tx_data/eng_rx_data/eng_ready - byte engine handshake
module spi_burst_arbiter
    import spi_pkg::*;
#(
    parameter int N         = 2,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int GUARD_CYC = GUARD_CYC_DEF,
    parameter int MAX_BYTES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [SPI_W*N-1:0] tx_byte,
    input  logic [N-1:0]       tx_last,
    output logic [N-1:0]       gnt,
    output logic               byte_done,
    output logic [SPI_W-1:0]   rx_byte,
    output logic               overrun,
    output logic               busy,
    output logic [N-1:0]       ss_n,
    output logic               eng_start,
    output logic [SPI_W-1:0]   eng_tx_data,
    input  logic [SPI_W-1:0]   eng_rx_data,
    input  logic               eng_ready
);

    localparam int PW   = $clog2(N);
    localparam int CW   = $clog2(MAX_BYTES + 1);
    localparam int TMAX = (SETUP_CYC > GUARD_CYC) ? SETUP_CYC : GUARD_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_tmr;
    logic             r_last;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_ss_n;
    logic             r_busy;
    logic             r_byte_done;
    logic             r_overrun;
    logic             r_eng_start;
    logic [SPI_W-1:0] r_eng_tx_data;
    logic [SPI_W-1:0] r_rx_byte;

    logic [N-1:0]     w_winner;
    logic             w_any;
    logic [PW-1:0]    w_win_idx;
    logic [CW-1:0]    w_cnt_inc;
    logic [SPI_W-1:0] w_tx_sel;
    logic             w_last_sel;

    spi_rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // One-hot winner to index, and mux of the granted requester's tx inputs.
    always_comb begin
        w_win_idx  = '0;
        w_tx_sel   = '0;
        w_last_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PW'(i);
            end else begin
                w_win_idx = w_win_idx;
            end
            if (r_ptr == PW'(i)) begin
                w_tx_sel   = tx_byte[i*SPI_W +: SPI_W];
                w_last_sel = tx_last[i];
            end else begin
                w_tx_sel   = w_tx_sel;
                w_last_sel = w_last_sel;
            end
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    // Burst FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any && eng_ready) begin
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (r_tmr == TW'(SETUP_CYC - 1)) begin
                    w_state_nxt = LAUNCH;
                end else begin
                    w_state_nxt = SETUP;
                end
            end
            LAUNCH: begin
                // While byte_done is showing, the requester has not yet
                // presented its next byte, so hold one cycle before sampling.
                if (r_byte_done) begin
                    w_state_nxt = LAUNCH;
                end else begin
                    w_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!eng_ready) begin
                    w_state_nxt = WAIT_HI;
                end else begin
                    w_state_nxt = WAIT_LO;
                end
            end
            WAIT_HI: begin
                if (eng_ready) begin
                    if (r_last || (w_cnt_inc == CW'(MAX_BYTES))) begin
                        w_state_nxt = GUARD;
                    end else begin
                        w_state_nxt = LAUNCH;
                    end
                end else begin
                    w_state_nxt = WAIT_HI;
                end
            end
            GUARD: begin
                if (r_tmr == TW'(GUARD_CYC - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GUARD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs, updated on the FSM transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= PW'(N - 1);
            r_cnt         <= '0;
            r_tmr         <= '0;
            r_last        <= 1'b0;
            r_gnt         <= '0;
            r_ss_n        <= '1;
            r_busy        <= 1'b0;
            r_byte_done   <= 1'b0;
            r_overrun     <= 1'b0;
            r_eng_start   <= 1'b0;
            r_eng_tx_data <= '0;
            r_rx_byte     <= '0;
        end else begin
            r_byte_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_eng_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any && eng_ready) begin
                        r_gnt  <= w_winner;
                        r_ss_n <= ~w_winner;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_ptr  <= w_win_idx;
                        r_tmr  <= '0;
                    end
                end
                SETUP: begin
                    r_tmr <= r_tmr + TW'(1);
                end
                LAUNCH: begin
                    if (!r_byte_done) begin
                        r_eng_start   <= 1'b1;
                        r_eng_tx_data <= w_tx_sel;
                        r_last        <= w_last_sel;
                    end
                end
                WAIT_HI: begin
                    if (eng_ready) begin
                        r_rx_byte   <= eng_rx_data;
                        r_byte_done <= 1'b1;
                        r_cnt       <= w_cnt_inc;
                        r_tmr       <= '0;
                        // A last byte landing exactly on the limit is a normal end.
                        if (!r_last && (w_cnt_inc == CW'(MAX_BYTES))) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                GUARD: begin
                    if (r_tmr == TW'(GUARD_CYC - 1)) begin
                        r_gnt  <= '0;
                        r_ss_n <= '1;
                        r_busy <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign ss_n        = r_ss_n;
    assign busy        = r_busy;
    assign byte_done   = r_byte_done;
    assign overrun     = r_overrun;
    assign rx_byte     = r_rx_byte;
    assign eng_start   = r_eng_start;
    assign eng_tx_data = r_eng_tx_data;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
module tb_spi_burst_arbiter;

    localparam int N  = 2;
    localparam int SC = 2;
    localparam int GC = 2;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] tx_byte;
    logic [1:0]  tx_last;
    logic [1:0]  gnt;
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic        overrun;
    logic        busy;
    logic [1:0]  ss_n;
    logic        eng_start;
    logic [7:0]  eng_tx_data;
    logic [7:0]  eng_rx_data;
    logic        eng_ready;

    always #5 clk = ~clk;

    spi_burst_arbiter #(.N(N), .SETUP_CYC(SC), .GUARD_CYC(GC), .MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .tx_byte(tx_byte), .tx_last(tx_last),
        .gnt(gnt), .byte_done(byte_done), .rx_byte(rx_byte), .overrun(overrun),
        .busy(busy), .ss_n(ss_n), .eng_start(eng_start), .eng_tx_data(eng_tx_data),
        .eng_rx_data(eng_rx_data), .eng_ready(eng_ready)
    );

    // Byte engine model: busy for 3 cycles per byte, returns tx ^ 8'h99.
    logic [7:0] rx_hold;
    int         ecnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_ready   <= 1'b1;
            eng_rx_data <= 8'h00;
            rx_hold     <= 8'h00;
            ecnt        <= 0;
        end else if (eng_start && eng_ready) begin
            eng_ready <= 1'b0;
            ecnt      <= 3;
            rx_hold   <= eng_tx_data ^ 8'h99;
        end else if (!eng_ready) begin
            if (ecnt == 1) begin
                eng_ready   <= 1'b1;
                eng_rx_data <= rx_hold;
            end
            ecnt <= ecnt - 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] tab [0:1][0:7];
    int pos [0:1];
    int blen [0:1];

    int cyc = 0;
    int n_start, n_done, n_ovr, ovr_idx, bad_ss, n_gnt, min_gap, gap;
    int rel_cyc, last_done_cyc, first_start_cyc, req_cyc;
    logic [7:0] start_data [0:15];
    logic [7:0] done_data [0:15];
    int gnt_seq [0:7];
    logic [1:0] prev_gnt = 2'b00;
    logic [1:0] prev_ss = 2'b11;
    logic bd_prev = 1'b0;
    int bd_who = 0;

    task automatic drive_data();
        for (int i = 0; i < 2; i++) begin
            int p;
            p = (pos[i] > 7) ? 7 : pos[i];
            tx_byte[i*8 +: 8] = tab[i][p];
            tx_last[i] = (pos[i] == blen[i] - 1);
        end
    endtask

    task automatic set_burst(input int i, input int len, input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < 8; k++) tab[i][k] = base + 8'(k) * step;
        blen[i] = len;
        pos[i] = 0;
        drive_data();
    endtask

    task automatic clear_log();
        n_start = 0; n_done = 0; n_ovr = 0; ovr_idx = -1; bad_ss = 0; n_gnt = 0;
        min_gap = 999; gap = 0; rel_cyc = -1; last_done_cyc = -1; first_start_cyc = -1;
        for (int k = 0; k < 8; k++) gnt_seq[k] = -1;
    endtask

    // One clock: sample outputs 1 time unit after the edge, model requesters.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bd_prev) pos[bd_who]++;
        drive_data();
        if (eng_start) begin
            if (n_start < 16) start_data[n_start] = eng_tx_data;
            if (n_start == 0) first_start_cyc = cyc;
            n_start++;
        end
        if (byte_done) begin
            if (n_done < 16) done_data[n_done] = rx_byte;
            n_done++;
            last_done_cyc = cyc;
        end
        if (overrun) begin
            n_ovr++;
            ovr_idx = byte_done ? n_done : 99;
        end
        if ((ss_n !== ~gnt) || ((gnt & (gnt - 2'b01)) != 2'b00)) bad_ss++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) begin
            if (n_gnt < 8) gnt_seq[n_gnt] = gnt[1] ? 1 : 0;
            if (n_gnt > 0 && gap < min_gap) min_gap = gap;
            n_gnt++;
        end
        if (gnt == 2'b00) gap++; else gap = 0;
        if (ss_n == 2'b11 && prev_ss != 2'b11) rel_cyc = cyc;
        if (gnt != 2'b00) req = req & ~gnt;
        bd_prev = byte_done;
        bd_who = gnt[1] ? 1 : 0;
        prev_gnt = gnt;
        prev_ss = ss_n;
    endtask

    task automatic run_until_idle(input int bound, output bit to);
        int k;
        k = 0;
        tick(); tick();
        while ((busy || req != 2'b00) && k < bound) begin tick(); k++; end
        to = (busy || req != 2'b00);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00;
        set_burst(0, 1, 8'h00, 8'h00); set_burst(1, 1, 8'h00, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if (ss_n !== 2'b11) $display("FAIL reset_ss_n: got %b want 11", ss_n); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (eng_start !== 1'b0) $display("FAIL reset_eng_start: got %b want 0", eng_start); else n_pass++;
        n_chk++; if (eng_tx_data !== 8'h00) $display("FAIL reset_eng_tx: got %h want 00", eng_tx_data); else n_pass++;
        n_chk++; if (rx_byte !== 8'h00) $display("FAIL reset_rx: got %h want 00", rx_byte); else n_pass++;
        n_chk++; if ({byte_done, overrun} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {byte_done, overrun}); else n_pass++;
        rst = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic test_single();
        bit to;
        set_burst(0, 1, 8'hA5, 8'h00);
        clear_log();
        req = 2'b01; req_cyc = cyc;
        run_until_idle(100, to);
        n_chk++; if (to) $display("FAIL single_timeout: busy=%b req=%b", busy, req); else n_pass++;
        n_chk++; if (gnt_seq[0] !== 0 || n_gnt !== 1) $display("FAIL single_gnt: got idx %0d n %0d want 0 1", gnt_seq[0], n_gnt); else n_pass++;
        n_chk++; if (first_start_cyc - req_cyc !== 4) $display("FAIL single_latency: got %0d want 4", first_start_cyc - req_cyc); else n_pass++;
        n_chk++; if (n_start !== 1 || start_data[0] !== 8'hA5) $display("FAIL single_start: got n %0d data %h want 1 a5", n_start, start_data[0]); else n_pass++;
        n_chk++; if (n_done !== 1 || done_data[0] !== 8'h3C) $display("FAIL single_rx: got n %0d data %h want 1 3c", n_done, done_data[0]); else n_pass++;
        n_chk++; if (rel_cyc - last_done_cyc !== 2) $display("FAIL single_guard: got %0d want 2", rel_cyc - last_done_cyc); else n_pass++;
        n_chk++; if (ss_n !== 2'b11 || busy !== 1'b0 || bad_ss !== 0) $display("FAIL single_end: ss_n %b busy %b bad %0d want 11 0 0", ss_n, busy, bad_ss); else n_pass++;
    endtask

    task automatic test_three_byte();
        bit to;
        set_burst(1, 3, 8'h11, 8'h11);
        clear_log();
        req = 2'b10;
        run_until_idle(200, to);
        n_chk++; if (to) $display("FAIL three_timeout: busy=%b", busy); else n_pass++;
        n_chk++; if (n_start !== 3 || start_data[0] !== 8'h11 || start_data[1] !== 8'h22 || start_data[2] !== 8'h33)
            $display("FAIL three_tx: got n %0d %h %h %h want 3 11 22 33", n_start, start_data[0], start_data[1], start_data[2]); else n_pass++;
        n_chk++; if (n_done !== 3 || done_data[0] !== 8'h88 || done_data[1] !== 8'hBB || done_data[2] !== 8'hAA)
            $display("FAIL three_rx: got n %0d %h %h %h want 3 88 bb aa", n_done, done_data[0], done_data[1], done_data[2]); else n_pass++;
        n_chk++; if (n_gnt !== 1 || gnt_seq[0] !== 1 || bad_ss !== 0 || n_ovr !== 0)
            $display("FAIL three_ss: n_gnt %0d idx %0d bad %0d ovr %0d want 1 1 0 0", n_gnt, gnt_seq[0], bad_ss, n_ovr); else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit to;
        set_burst(0, 1, 8'h5A, 8'h00); set_burst(1, 1, 8'h6B, 8'h00);
        clear_log();
        req = 2'b11;
        run_until_idle(200, to);
        n_chk++; if (to) $display("FAIL simul_timeout1: busy=%b req=%b", busy, req); else n_pass++;
        set_burst(0, 1, 8'h5A, 8'h00); set_burst(1, 1, 8'h6B, 8'h00);
        req = 2'b11;
        run_until_idle(200, to);
        n_chk++; if (to) $display("FAIL simul_timeout2: busy=%b req=%b", busy, req); else n_pass++;
        n_chk++; if (n_gnt !== 4 || gnt_seq[0] !== 0 || gnt_seq[1] !== 1 || gnt_seq[2] !== 0 || gnt_seq[3] !== 1)
            $display("FAIL simul_order: n %0d seq %0d %0d %0d %0d want 4 0 1 0 1", n_gnt, gnt_seq[0], gnt_seq[1], gnt_seq[2], gnt_seq[3]); else n_pass++;
        n_chk++; if (min_gap !== 1) $display("FAIL simul_gap: got %0d want 1", min_gap); else n_pass++;
        n_chk++; if (bad_ss !== 0) $display("FAIL simul_ss: got %0d want 0", bad_ss); else n_pass++;
    endtask

    task automatic test_midburst();
        bit to;
        int k;
        set_burst(0, 3, 8'h01, 8'h01);
        clear_log();
        req = 2'b01;
        k = 0;
        while (n_start < 1 && k < 50) begin tick(); k++; end
        set_burst(1, 1, 8'h44, 8'h00);
        req[1] = 1'b1;
        run_until_idle(300, to);
        n_chk++; if (to) $display("FAIL mid_timeout: busy=%b req=%b", busy, req); else n_pass++;
        n_chk++; if (n_start !== 4 || start_data[0] !== 8'h01 || start_data[1] !== 8'h02 || start_data[2] !== 8'h03 || start_data[3] !== 8'h44)
            $display("FAIL mid_tx: n %0d %h %h %h %h want 4 01 02 03 44", n_start, start_data[0], start_data[1], start_data[2], start_data[3]); else n_pass++;
        n_chk++; if (n_gnt !== 2 || gnt_seq[0] !== 0 || gnt_seq[1] !== 1 || bad_ss !== 0)
            $display("FAIL mid_gnt: n %0d seq %0d %0d bad %0d want 2 0 1 0", n_gnt, gnt_seq[0], gnt_seq[1], bad_ss); else n_pass++;
    endtask

    task automatic test_overrun();
        bit to;
        set_burst(1, 8, 8'hA0, 8'h01);
        clear_log();
        req = 2'b10;
        run_until_idle(300, to);
        n_chk++; if (to) $display("FAIL ovr_timeout: busy=%b", busy); else n_pass++;
        n_chk++; if (n_done !== 4 || n_start !== 4 || start_data[3] !== 8'hA3 || done_data[0] !== 8'h39 || done_data[3] !== 8'h3A)
            $display("FAIL ovr_bytes: done %0d start %0d tx3 %h rx0 %h rx3 %h want 4 4 a3 39 3a", n_done, n_start, start_data[3], done_data[0], done_data[3]); else n_pass++;
        n_chk++; if (n_ovr !== 1 || ovr_idx !== 4) $display("FAIL ovr_pulse: n %0d at %0d want 1 4", n_ovr, ovr_idx); else n_pass++;
        n_chk++; if (rel_cyc - last_done_cyc !== 2 || ss_n !== 2'b11) $display("FAIL ovr_guard: got %0d ss_n %b want 2 11", rel_cyc - last_done_cyc, ss_n); else n_pass++;
    endtask

    task automatic test_max_exact();
        bit to;
        set_burst(0, 4, 8'hC1, 8'h01);
        clear_log();
        req = 2'b01;
        run_until_idle(300, to);
        n_chk++; if (to) $display("FAIL exact_timeout: busy=%b", busy); else n_pass++;
        n_chk++; if (n_done !== 4 || n_ovr !== 0 || start_data[3] !== 8'hC4 || done_data[3] !== 8'h5D)
            $display("FAIL exact_end: done %0d ovr %0d tx3 %h rx3 %h want 4 0 c4 5d", n_done, n_ovr, start_data[3], done_data[3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        set_burst(0, 3, 8'h10, 8'h10);
        clear_log();
        req = 2'b01;
        k = 0;
        while (!(n_start == 2 && !eng_ready) && k < 100) begin tick(); k++; end
        tick();
        n_chk++; if (gnt !== 2'b01 || n_done !== 1 || eng_ready !== 1'b0)
            $display("FAIL rstmid_pre: gnt %b done %0d ready %b want 01 1 0", gnt, n_done, eng_ready); else n_pass++;
        rst = 1'b1;
        #2;
        n_chk++; if (ss_n !== 2'b11 || gnt !== 2'b00 || busy !== 1'b0)
            $display("FAIL rstmid_async: ss_n %b gnt %b busy %b want 11 00 0", ss_n, gnt, busy); else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        prev_gnt = 2'b00; prev_ss = 2'b11; bd_prev = 1'b0;
        set_burst(0, 1, 8'h77, 8'h00); set_burst(1, 1, 8'h78, 8'h00);
        clear_log();
        req = 2'b11;
        run_until_idle(200, to);
        n_chk++; if (to) $display("FAIL rstmid_timeout: busy=%b req=%b", busy, req); else n_pass++;
        n_chk++; if (gnt_seq[0] !== 0 || gnt_seq[1] !== 1) $display("FAIL rstmid_order: seq %0d %0d want 0 1", gnt_seq[0], gnt_seq[1]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_byte();
        test_simultaneous();
        test_midburst();
        test_overrun();
        test_max_exact();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_burst_arbiter.md
Name: spi_burst_arbiter

Overview:
- Shares one 8-bit SPI byte engine between N requesters.
- Grants one requester at a time (round-robin) and holds that requester's slave-select low for a whole multi-byte burst.
- Launches the engine once per byte and returns each received byte to the granted requester.
- Sits between client logic and the SPI byte engine. The engine's own cs output is unused; ss_n from this block drives the slaves.

Parameters:
N, 2, number of requesters/slaves (2..8)
SETUP_CYC, 2, clk cycles from ss_n fall to first engine start (>=1)
GUARD_CYC, 2, clk cycles ss_n held low after last byte before release (>=1)
MAX_BYTES, 16, burst length limit; burst force-terminated at this count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  N  per-requester burst request, level, held until gnt
tx_byte  in  8*N  per-requester next byte to send (slice i = requester i)
tx_last  in  N  per-requester: current tx_byte is final byte of burst
gnt  out  N  one-hot grant, held for entire burst
byte_done  out  1  one-cycle pulse: byte finished; requester advances tx_byte/tx_last next cycle
rx_byte  out  8  received byte, valid when byte_done=1, held otherwise
overrun  out  1  one-cycle pulse: burst force-ended at MAX_BYTES
busy  out  1  high from grant until return to IDLE
ss_n  out  N  active-low slave selects, at most one low
eng_start  out  1  one-cycle start to byte engine
eng_tx_data  out  8  byte to engine, stable from eng_start until byte done
eng_rx_data  in  8  engine received byte
eng_ready  in  1  engine idle flag

Behaviour:
- Reset (async, rst=1):
  - State IDLE; gnt=0, ss_n=all 1, eng_start=0, eng_tx_data=0, rx_byte=0, byte_done=0, overrun=0, busy=0.
  - RR pointer=N-1, so requester 0 wins first.
  - Reset mid-burst releases ss_n immediately. The engine shares reset; no abort handshake.
- All outputs are registered.
- States:
  - IDLE:
    - If any req and eng_ready=1: pick the winner, searching from pointer+1 with wrap.
    - Next cycle: gnt[w]=1, ss_n[w]=0, busy=1, byte count=0, pointer=w. Go to SETUP.
    - No grant while eng_ready=0.
  - SETUP: count SETUP_CYC cycles, then go to LAUNCH.
  - LAUNCH:
    - Assert eng_start=1 for exactly one cycle.
    - Latch eng_tx_data=tx_byte[w] and last_q=tx_last[w].
    - Go to WAIT_LO.
  - WAIT_LO: wait for eng_ready=0, then go to WAIT_HI.
  - WAIT_HI: on eng_ready=1:
    - rx_byte<=eng_rx_data, byte_done=1 (one cycle), count+1.
    - If last_q=1: go to GUARD.
    - Else if count+1==MAX_BYTES: overrun=1, go to GUARD.
    - Else: go to LAUNCH.
  - GUARD:
    - Count GUARD_CYC cycles.
    - Then ss_n=all 1, gnt=0, busy=0, go to IDLE.
- Minimum latency: req to first eng_start = 1 + SETUP_CYC + 1 cycles.
- Minimum IDLE gap between bursts: 1 cycle. A new grant is never issued in the same cycle gnt drops.
- Requests:
  - req changes during a burst are ignored. Dropping req does not end the burst; only tx_last or MAX_BYTES ends it.
  - Non-granted req wait; no starvation, because every waiting requester is granted within N bursts.
- Simultaneous req: round-robin order relative to the last winner.
- Byte counter width is clog2(MAX_BYTES+1). Count MAX_BYTES with tx_last=1 is a normal end; overrun does not fire.
- tx_byte/tx_last of non-granted requesters are never sampled.

Decomposition:
- Shared package spi_pkg:
  - State enum: IDLE, SETUP, LAUNCH, WAIT_LO, WAIT_HI, GUARD.
  - Default timing constants SETUP_CYC_DEF and GUARD_CYC_DEF.
  - Byte width constant SPI_W=8.
- One sub-module, spi_rr_arbiter (combinational one-hot pick from req and pointer):
  - Ports: req[N], ptr, winner one-hot, any.
  - Registered pointer stays in the parent.

Test Plan:
- Single-byte burst: req[0]=1, tx_byte0=8'hA5, tx_last0=1; engine model echoes 8'h3C.
  -> gnt=01, ss_n[0] low, one eng_start with eng_tx_data=A5, byte_done with rx_byte=3C, ss_n high after GUARD_CYC, busy=0.
- 3-byte burst on requester 1: bytes 11,22,33 (last on 33).
  -> exactly 3 eng_start pulses in order, ss_n[1] low continuously, 3 byte_done pulses, no overrun.
- Simultaneous req=11 twice, each a 1-byte burst.
  -> first grant requester 0, then requester 1, then 0 again; ss_n never both low; at least 1 IDLE cycle between bursts.
- Requester 1 asserts req mid-burst of requester 0 and requester 0 drops req mid-burst.
  -> requester 0 burst completes to tx_last; requester 1 granted afterward.
- tx_last held 0 with MAX_BYTES=4.
  -> 4 byte_done pulses, overrun pulse coincident with 4th, ss_n released after guard.
- rst=1 during WAIT_HI of byte 2.
  -> ss_n all 1, gnt=0, busy=0 immediately (same cycle, async); after release, requester 0 granted first.
